// File: rtl/sram_confreg_resp.sv
// Data-side SRAM port that serves a word RAM plus a small block of board
// registers (free-running timer, LEDs, seven-segment, synchronised switches).
module sram_confreg_resp #(
    parameter int          RAM_AW    = 10,
    parameter logic [15:0] CONF_BASE = 16'hbfaf
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] seg_out
);

    localparam logic [15:0] OFF_TIMER  = 16'he000;
    localparam logic [15:0] OFF_LED    = 16'hf000;
    localparam logic [15:0] OFF_SEG    = 16'hf010;
    localparam logic [15:0] OFF_SWITCH = 16'hf020;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return res;
    endfunction

    logic              acc;
    logic              wr;
    logic              is_conf;
    logic [15:0]       offset;
    logic [RAM_AW-1:0] ram_idx;

    // Accesses are dropped outright while reset is held.
    assign acc     = data_sram_en & resetn;
    assign wr      = acc & (|data_sram_wen);
    assign is_conf = (data_sram_addr[31:16] == CONF_BASE);
    assign offset  = data_sram_addr[15:0];
    assign ram_idx = data_sram_addr[RAM_AW+1:2];

    logic [31:0] mem [0:(2**RAM_AW)-1];
    logic [31:0] ram_q;

    // Read-first: ram_q captures the old word in the same edge as the write.
    always_ff @(posedge clk) begin
        if (acc && !is_conf) begin
            ram_q <= mem[ram_idx];
            for (int i = 0; i < 4; i++)
                if (data_sram_wen[i])
                    mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
    end

    logic [31:0] timer;
    logic [15:0] led;
    logic [31:0] seg;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;
    logic [31:0] rd_conf;
    logic        rd_sel_ram;
    logic [31:0] conf_rd;
    logic [31:0] timer_wr;
    logic [31:0] led_wr;
    logic [31:0] seg_wr;

    always_comb begin
        conf_rd = '0;
        case (offset)
            OFF_TIMER:  conf_rd = timer;
            OFF_LED:    conf_rd = {16'h0, led};
            OFF_SEG:    conf_rd = seg;
            OFF_SWITCH: conf_rd = {24'h0, sw_sync};
            default:    conf_rd = '0;
        endcase
    end

    assign timer_wr = byte_merge(timer, data_sram_wdata, data_sram_wen);
    assign led_wr   = byte_merge({16'h0, led}, data_sram_wdata, data_sram_wen);
    assign seg_wr   = byte_merge(seg, data_sram_wdata, data_sram_wen);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer      <= '0;
            led        <= '0;
            seg        <= '0;
            sw_meta    <= '0;
            sw_sync    <= '0;
            rd_conf    <= '0;
            rd_sel_ram <= 1'b0;
        end else begin
            sw_meta <= switch_in;
            sw_sync <= sw_meta;
            if (wr && is_conf && offset == OFF_TIMER)
                timer <= timer_wr;
            else
                timer <= timer + 32'd1;
            if (wr && is_conf && offset == OFF_LED)
                led <= led_wr[15:0];
            if (wr && is_conf && offset == OFF_SEG)
                seg <= seg_wr;
            if (acc) begin
                rd_sel_ram <= !is_conf;
                if (is_conf)
                    rd_conf <= conf_rd;
            end
        end
    end

    // Both sources are registered; reset clears the select and rd_conf so
    // the port reads 0 immediately.
    assign data_sram_rdata = rd_sel_ram ? ram_q : rd_conf;
    assign led_out         = led;
    assign seg_out         = seg;

endmodule

// File: doc/sram_confreg_resp.md
SRAM_CONFREG_RESP -- requirements
Module: sram_confreg_resp

Interface
- REQ-001 SHALL have parameter RAM_AW, default 10, meaning RAM word-address width (2^RAM_AW 32-bit words).
- REQ-002 SHALL have parameter CONF_BASE, default 16'hbfaf, meaning the addr[31:16] value that selects the register region.
- REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
- REQ-004 SHALL have port resetn, input, 1, reset; asynchronous, active-low.
- REQ-005 SHALL have port data_sram_en, input, 1, access request this cycle.
- REQ-006 SHALL have port data_sram_wen, input, 4, per-byte write enable; wen[i] writes bits [8i+7:8i].
- REQ-007 SHALL have port data_sram_addr, input, 32, byte address; addr[1:0] ignored.
- REQ-008 SHALL have port data_sram_wdata, input, 32, write data.
- REQ-009 SHALL have port data_sram_rdata, output, 32, registered read data.
- REQ-010 SHALL have port switch_in, input, 8, asynchronous board switches.
- REQ-011 SHALL have port led_out, output, 16, LED register value.
- REQ-012 SHALL have port seg_out, output, 32, seven-segment register value.

Function
- REQ-013 SHALL decode as a register access when addr[31:16]==CONF_BASE, else as a RAM access to word addr[RAM_AW+1:2] (upper bits aliased).
- REQ-014 SHALL map register offsets addr[15:0]: 16'he000 TIMER (rw, 32b), 16'hf000 LED (rw, low 16b), 16'hf010 SEG (rw, 32b), 16'hf020 SWITCH (ro, low 8b, upper 24b read 0).
- REQ-015 SHALL return 0 on reads of unmapped register offsets and ignore writes to them and to SWITCH.
- REQ-016 SHALL, when en=1, present read data on data_sram_rdata at the next rising edge (1-cycle latency); when en=0, hold data_sram_rdata unchanged.
- REQ-017 SHALL perform a write only when en=1 and wen!=0, merging only enabled bytes with the old contents.
- REQ-018 SHALL be read-first: an access with en=1 and wen!=0 returns the pre-write word on data_sram_rdata.
- REQ-019 SHALL increment TIMER by 1 every cycle out of reset, wrapping 32'hffffffff to 0.
- REQ-020 SHALL, on a TIMER write, load the byte-merged value (merged with the current pre-increment value) instead of incrementing that cycle.
- REQ-021 SHALL return on a TIMER read the value held during the request cycle (before that cycle's increment).
- REQ-022 SHALL synchronise switch_in through two flops; SWITCH reads return the second-stage value.
- REQ-023 SHALL drive led_out and seg_out directly from the LED and SEG registers; updates are visible the cycle after the write edge.
- REQ-024 SHALL implement RAM as inferable synchronous memory with no reset; initial contents are undefined.

Reset
- REQ-025 SHALL, while resetn=0, force data_sram_rdata=0, TIMER=0, LED=0, SEG=0 and both switch sync stages to 0, immediately and independently of clk.
- REQ-026 SHALL ignore any access in a cycle where resetn is low; a read issued in the cycle resetn deasserts completes normally.
- REQ-027 SHALL NOT alter RAM contents on reset; a write in flight at reset assertion may be lost.

Verification
- REQ-028 SHALL cover RAM byte write: write 32'h11223344 wen=4'hf to 0x00000010, then wen=4'b0101 wdata 32'haabbccdd, then read -> rdata 32'h11bb33dd one cycle after the read.
- REQ-029 SHALL cover read-first: read 0x10 with wen=4'hf wdata 0 in the same cycle -> rdata 32'h11bb33dd; a following read -> 0.
- REQ-030 SHALL cover TIMER: after reset release, write 32'hfffffffe to 0xbfafe000, then read on the next and the following cycle -> 32'hfffffffe then 32'hffffffff; a third read -> 0 (wrap).
- REQ-031 SHALL cover LED/SEG: write 32'h0001beef to 0xbfaff000 -> led_out 16'hbeef; read back -> 32'h0000beef; write to 0xbfaff020 has no effect.
- REQ-032 SHALL cover SWITCH sync: set switch_in=8'h5a -> a read of 0xbfaff020 issued fewer than 2 cycles later returns the old value; issued 2+ cycles later returns 32'h0000005a.
- REQ-033 SHALL cover reset mid-operation: assert resetn=0 between clock edges after a read -> rdata, led_out, seg_out become 0 immediately; RAM word written before reset reads back unchanged afterwards.
